// File: rtl/wb_commit_stage.sv
// -----------------------------------------------------------------------------
// wb_commit_stage
//
// Write-back stage that sits between memory access and the register file.
// Completed instructions arrive on a valid/ready handshake, are formatted at
// push time (ALU result, or the aligned and sign/zero-extended load data), are
// buffered in a small FIFO and then committed to the register file write port
// at most one per cycle. Committed entries are counted in retireCount.
//
// An empty buffer with no hold passes the incoming entry straight through, so
// it reaches the write port after a single edge.
//
// Optional feature (macro WB_BYPASS_EN):
//   Adds readAddrF/readAddrS inputs and bypassHitF/bypassHitS/bypassData
//   outputs. These let decode forward the write that is on the port this cycle.
//
// Ports:
//   clk           system clock, rising edge
//   resetIn       synchronous active-high reset
//   memValid      upstream entry valid
//   memReady      buffer has room (from registered occupancy only)
//   memRdAddr     destination register
//   memRegWrite   instruction writes rd
//   memResultSel  0 = ALU result, 1 = load data
//   memAluResult  ALU result
//   memLoadData   raw aligned word from data memory
//   memLoadType   load funct3 (LB/LH/LW/LBU/LHU)
//   memAddrLow    byte offset of the load address
//   holdIn        freeze commit (pushes still accepted)
//   resetOut      registered copy of resetIn
//   writeEnable   register file write strobe
//   writeAddr     register file write address
//   writeDate     register file write data
//   misalignErr   one-cycle pulse for a committed misaligned/illegal load
//   retireCount   committed entry counter (wraps)
// -----------------------------------------------------------------------------
module wb_commit_stage #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            resetIn,
`ifdef WB_BYPASS_EN
   input  logic [4:0]      readAddrF,
   input  logic [4:0]      readAddrS,
   output logic            bypassHitF,
   output logic            bypassHitS,
   output logic [XLEN-1:0] bypassData,
`endif
   input  logic            memValid,
   output logic            memReady,
   input  logic [4:0]      memRdAddr,
   input  logic            memRegWrite,
   input  logic            memResultSel,
   input  logic [XLEN-1:0] memAluResult,
   input  logic [XLEN-1:0] memLoadData,
   input  logic [2:0]      memLoadType,
   input  logic [1:0]      memAddrLow,
   input  logic            holdIn,
   output logic            resetOut,
   output logic            writeEnable,
   output logic [4:0]      writeAddr,
   output logic [XLEN-1:0] writeDate,
   output logic            misalignErr,
   output logic [31:0]     retireCount
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [4:0]      rd;
      logic            reg_write;
      logic            err;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t            entry_mem [DEPTH];
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic [PTR_W-1:0]  head_reg;
   logic [PTR_W-1:0]  tail_reg;

   logic              write_en_reg;
   logic [4:0]        write_addr_reg;
   logic [XLEN-1:0]   write_data_reg;
   logic              misalign_err_reg;
   logic [31:0]       retire_count_reg;
   logic              reset_out_reg;

   logic [7:0]        load_byte;
   logic [15:0]       load_half;
   logic [XLEN-1:0]   fmt_data;
   logic              fmt_err;
   entry_t            in_entry;
   entry_t            pop_entry;

   logic              push;
   logic              pop;
   logic              pass_through;
   logic              store;
   logic              read_head;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // ---------------------------------------------------------------------------
   // Push-time formatting
   // ---------------------------------------------------------------------------
   always_comb begin
      load_byte = memLoadData[7:0];
      case (memAddrLow)
         2'd0:    load_byte = memLoadData[7:0];
         2'd1:    load_byte = memLoadData[15:8];
         2'd2:    load_byte = memLoadData[23:16];
         default: load_byte = memLoadData[31:24];
      endcase
   end

   assign load_half = memAddrLow[1] ? memLoadData[31:16] : memLoadData[15:0];

   always_comb begin
      fmt_data = memAluResult;
      fmt_err  = 1'b0;
      if (memResultSel) begin
         // Illegal encodings keep the raw word; the entry is flagged anyway.
         fmt_data = memLoadData;
         case (memLoadType)
            3'b000: fmt_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b100: fmt_data = {{(XLEN-8){1'b0}}, load_byte};
            3'b001: begin
               fmt_data = {{(XLEN-16){load_half[15]}}, load_half};
               fmt_err  = memAddrLow[0];
            end
            3'b101: begin
               fmt_data = {{(XLEN-16){1'b0}}, load_half};
               fmt_err  = memAddrLow[0];
            end
            3'b010:  fmt_err = (memAddrLow != 2'b00);
            default: fmt_err = 1'b1;
         endcase
      end
   end

   always_comb begin
      in_entry           = '0;
      in_entry.rd        = memRdAddr;
      in_entry.reg_write = memRegWrite;
      in_entry.err       = fmt_err;
      in_entry.data      = fmt_data;
   end

   // ---------------------------------------------------------------------------
   // Handshake and buffer control
   // ---------------------------------------------------------------------------
   assign memReady     = (count_reg < CNT_W'(DEPTH));
   assign push         = memValid && memReady;
   assign pop          = !holdIn && ((count_reg != '0) || push);
   // With an empty buffer the popped entry is the incoming one; it never
   // touches storage.
   assign pass_through = pop && (count_reg == '0);
   assign store        = push && !pass_through;
   assign read_head    = pop && (count_reg != '0);
   assign pop_entry    = (count_reg != '0) ? entry_mem[head_reg] : in_entry;

   always_comb begin
      count_next = count_reg;
      if (store && !read_head) begin
         count_next = count_reg + 1'b1;
      end else if (read_head && !store) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (resetIn) begin
         count_reg        <= '0;
         head_reg         <= '0;
         tail_reg         <= '0;
         write_en_reg     <= 1'b0;
         write_addr_reg   <= '0;
         write_data_reg   <= '0;
         misalign_err_reg <= 1'b0;
         retire_count_reg <= '0;
      end else begin
         if (store) begin
            entry_mem[tail_reg] <= in_entry;
            tail_reg            <= next_ptr(tail_reg);
         end
         if (read_head) begin
            head_reg <= next_ptr(head_reg);
         end
         count_reg <= count_next;

         if (pop) begin
            write_addr_reg   <= pop_entry.rd;
            write_data_reg   <= pop_entry.data;
            write_en_reg     <= pop_entry.reg_write && (pop_entry.rd != 5'd0) && !pop_entry.err;
            misalign_err_reg <= pop_entry.err && pop_entry.reg_write;
            retire_count_reg <= retire_count_reg + 32'd1;
         end else begin
            write_en_reg     <= 1'b0;
            misalign_err_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      reset_out_reg <= resetIn;
   end

   assign resetOut    = reset_out_reg;
   assign writeEnable = write_en_reg;
   assign writeAddr   = write_addr_reg;
   assign writeDate   = write_data_reg;
   assign misalignErr = misalign_err_reg;
   assign retireCount = retire_count_reg;

`ifdef WB_BYPASS_EN
   // Forward the write on the port this cycle; the register file read does
   // not see it until the next cycle.
   assign bypassHitF = write_en_reg && (write_addr_reg == readAddrF);
   assign bypassHitS = write_en_reg && (write_addr_reg == readAddrS);
   assign bypassData = write_data_reg;
`endif

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
- Write-back stage between the memory-access stage and the register file.
- Buffers completed instructions with a valid/ready handshake and selects the ALU result or the aligned, extended load data.
- Drives the register file write port (writeEnable/writeAddr/writeDate) one entry per cycle and counts retired instructions.

Parameters:
- DEPTH, 2, number of entries in the commit buffer (≥1).
- XLEN, 32, datapath width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetIn  input  1  reset, synchronous, active-high.
- memValid  input  1  upstream entry valid.
- memReady  output  1  stage can accept an entry this cycle.
- memRdAddr  input  5  destination register.
- memRegWrite  input  1  instruction writes rd.
- memResultSel  input  1  0 = ALU result, 1 = load data.
- memAluResult  input  XLEN  ALU result / store-load address.
- memLoadData  input  XLEN  raw aligned word read from data memory.
- memLoadType  input  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- memAddrLow  input  2  byte offset of the load address.
- holdIn  input  1  hazard unit freezes commit.
- resetOut  output  1  registered copy of resetIn for the downstream stage.
- writeEnable  output  1  register file write strobe.
- writeAddr  output  5  register file write address.
- writeDate  output  XLEN  register file write data.
- misalignErr  output  1  one-cycle pulse: committed load was misaligned or illegal.
- retireCount  output  32  number of committed entries.

Behaviour:
- Reset (resetIn=1 at an edge): buffer emptied, count=0, writeEnable=0, writeAddr=0, writeDate=0, misalignErr=0, retireCount=0, resetOut=1. First edge with resetIn=0 sets resetOut=0.
- memReady = (count < DEPTH), from registered count only. memReady does not depend on holdIn or memValid.
- Push: occurs when memValid && memReady at an edge. Data formatting is done at push time, and the formatted entry is stored.
- Load formatting (memResultSel=1):
  - LB/LBU: byte memAddrLow, sign/zero-extended.
  - LH/LHU: halfword memAddrLow[1], sign/zero-extended.
  - LW: whole word.
- Error cases:
  - LH/LHU with memAddrLow[0]=1 is misaligned.
  - LW with memAddrLow≠0 is misaligned.
  - funct3 011/110/111 is illegal.
  - Misaligned and illegal entries both set the error flag.
- ALU path (memResultSel=0): memAluResult passes unchanged; error flag is 0.
- Pop: occurs at an edge when !holdIn and (count>0 or push). Entry priority is head of buffer, else the incoming entry (pass-through). At a pop:
  - Output registers load writeAddr=rd and writeDate=data.
  - writeEnable = regWrite && rd≠0 && !err.
  - misalignErr = err && regWrite.
  - retireCount increments by 1 and wraps 0xFFFFFFFF→0.
- No pop at an edge: writeEnable=0 and misalignErr=0. writeAddr/writeDate hold their last values.
- Latency:
  - Empty buffer, no hold: push at edge N is visible on the write port after edge N (1 cycle).
  - Otherwise, FIFO order is preserved.
- Simultaneous push and pop: count unchanged. Push while full is impossible (memReady=0).
- holdIn asserted: no pops and outputs deassert strobes. Pushes continue until full.
- Reset mid-operation: buffered entries are discarded without being committed; retireCount is not incremented.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Adds inputs readAddrF and readAddrS (5 bits each).
  - Adds outputs bypassHitF and bypassHitS (1 bit each) and bypassData (XLEN).
  - bypassHitX = writeEnable && (writeAddr == readAddrX), combinational.
  - bypassData = writeDate.
  - Lets decode forward a same-cycle write that the register file read does not yet return.
- Undefined: these ports and the logic do not exist; the stage behaviour is otherwise identical.

Test Plan:
- Reset, then ALU entry rd=5, data 0x12345678, empty buffer -> next cycle writeEnable=1, writeAddr=5, writeDate=0x12345678, retireCount=1.
- LB, memLoadData=0x80FF7F01, memAddrLow=2 -> writeDate=0xFFFFFFFF. LBU at offset 3 -> 0x00000080. LH at offset 2 -> 0xFFFF80FF.
- LW with memAddrLow=1, rd=7 -> writeEnable=0, misalignErr=1 for one cycle, retireCount increments. rd=0 ALU entry -> writeEnable=0, misalignErr=0.
- holdIn=1 while three entries are offered (DEPTH=2) -> memReady drops after 2 pushes. Release holdIn -> entries commit in order on 2 consecutive cycles, and memReady returns to 1 after the first pop.
- Assert resetIn with 2 buffered entries -> no write strobe, retireCount=0, resetOut=1 for one cycle after release.
- WB_BYPASS_EN: commit rd=9 while readAddrF=9 and readAddrS=3 -> bypassHitF=1, bypassHitS=0, bypassData=writeDate.
